ram_dtack: RTL

//  Synchronous single-port block RAM with per-byte write lanes, a programmable

---
 rtl/ram_dtack.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ram_dtack.sv
// Single-port block RAM with byte-write lanes, programmable wait states and a
// 68000-style DTACK handshake between the CPU bus decoder and on-chip memory.
module ram_dtack #(
    parameter string MEM_INIT_FILE = "",
    parameter int    DATA_WIDTH    = 16,
    parameter int    BYTE_WIDTH    = 8,
    parameter int    DEPTH         = 16384,
    parameter int    ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int    WAIT_STATES   = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cs,
    input  logic                             we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
    input  logic [ADDRESS_WIDTH-1:0]         addr,
    input  logic [DATA_WIDTH-1:0]            din,
    output logic [DATA_WIDTH-1:0]            dout,
    output logic                             dtack
);

    localparam int                     LANES     = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] DEPTH_W   = (ADDRESS_WIDTH + 1)'(DEPTH);
    localparam logic [3:0]             WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        ACK
    } state_e;

    state_e                     state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic                       we_q, we_d;
    logic [LANES-1:0]           be_q, be_d;
    logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]      din_q, din_d;
    logic                       in_range_q, in_range_d;
    logic                       rd_pend_q, rd_pend_d;
    logic [DATA_WIDTH-1:0]      dout_q, dout_d;
    logic                       dtack_q, dtack_d;

    logic [DATA_WIDTH-1:0]      mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0]      ram_rd_q;
    logic                       wr_en;
    logic                       rd_en;

    assign wr_en = (state_q == ACCESS) && we_q && in_range_q;
    assign rd_en = (state_q == ACCESS) && !we_q && in_range_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        din_d      = din_q;
        in_range_d = in_range_q;
        rd_pend_d  = 1'b0;
        dout_d     = dout_q;
        dtack_d    = 1'b0;

        // Block RAM output lands one cycle after ACCESS; lane masking happens here.
        if (rd_pend_q) begin
            for (int i = 0; i < LANES; i++) begin
                dout_d[i*BYTE_WIDTH +: BYTE_WIDTH] = (be_q[i] && in_range_q)
                    ? ram_rd_q[i*BYTE_WIDTH +: BYTE_WIDTH] : '0;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (cs) begin
                    we_d       = we;
                    be_d       = be;
                    addr_d     = addr;
                    din_d      = din;
                    in_range_d = ({1'b0, addr} < DEPTH_W);
                    if (WAIT_STATES == 0) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!cs) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q <= 4'd1) begin
                    state_d = ACCESS;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACCESS: begin
                rd_pend_d = !we_q;
                state_d   = cs ? ACK : IDLE;
            end
            ACK: begin
                if (cs) begin
                    dtack_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            in_range_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            dout_q     <= '0;
            dtack_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            in_range_q <= in_range_d;
            rd_pend_q  <= rd_pend_d;
            dout_q     <= dout_d;
            dtack_q    <= dtack_d;
        end
    end

    // NOTE: the array and its read register carry no reset so they map onto block RAM; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (be_q[i]) begin
                    mem[addr_q][i*BYTE_WIDTH +: BYTE_WIDTH] <= din_q[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
        if (rd_en) begin
            ram_rd_q <= mem[addr_q];
        end
    end

    assign dout  = dout_q;
    assign dtack = dtack_q;

endmodule
